freq_hist: RTL and testbench
============================

FREQ_HIST -- requirements
Module: freq_hist

Interface
REQ-001 The block SHALL have parameter SYM_W, default 4, meaning symbol width in bits.
REQ-002 The block SHALL have parameter NUM_SYM, default 10, meaning number of counted bins (2 to 2^SYM_W).
REQ-003 The block SHALL have parameter CNT_W, default 8, meaning width of each bin counter.
REQ-004 The block SHALL have parameter LEN_W, default 16, meaning width of the total-symbol counter.
REQ-005 The block SHALL have port clk, input, 1, the clock; all logic rises on posedge clk.
REQ-006 The block SHALL have port rst_n, input, 1, the reset, which is asynchronous and active-low.
REQ-007 The block SHALL have port start, input, 1, a one-cycle pulse that begins a new histogram.
REQ-008 The block SHALL have port din_valid, input, 1, which qualifies din.
REQ-009 The block SHALL have port din, input, SYM_W, the symbol.
REQ-010 The block SHALL have port din_last, input, 1, which marks the final symbol and is sampled only with din_valid.
REQ-011 The block SHALL have port ack, input, 1, the acknowledge from the coding stage.
REQ-012 The block SHALL have port req, output, 1, the histogram-ready request.
REQ-013 The block SHALL have port busy, output, 1, which is high in states COUNT and REQ.
REQ-014 The block SHALL have port cnt_out, output, NUM_SYM*CNT_W, holding packed bin counts with bin k at bits [k*CNT_W +: CNT_W].
REQ-015 The block SHALL have port total, output, LEN_W, the count of accepted symbols.
REQ-016 The block SHALL have port num_active, output, $clog2(NUM_SYM+1), the number of nonzero bins.
REQ-017 The block SHALL have port oor_err, output, 1, a sticky flag set when a symbol >= NUM_SYM is seen.

Function
REQ-018 The FSM SHALL have states IDLE, COUNT and REQ.
REQ-019 In IDLE, start SHALL move the FSM to COUNT and clear all bins, total, oor_err and the saturation flag on the same edge.
REQ-020 In COUNT, din_valid with din < NUM_SYM SHALL increment bin[din] and total, with the result visible the cycle after the sample.
REQ-021 In COUNT, din_valid with din >= NUM_SYM SHALL set oor_err, increment total and leave all bins unchanged.
REQ-022 din_valid with din_last in COUNT SHALL count that symbol per REQ-020/021, move the FSM to REQ and raise req on the same edge.
REQ-023 din_last without din_valid SHALL be ignored.
REQ-024 start in COUNT SHALL restart the histogram (clear per REQ-019, remain in COUNT), and any din_valid in that cycle SHALL be discarded.
REQ-025 In REQ, cnt_out, total, num_active and oor_err SHALL be frozen, and start and din_valid SHALL be ignored.
REQ-026 In REQ, ack SHALL move the FSM to IDLE and deassert req on the next edge; ack outside REQ SHALL be ignored.
REQ-027 Counts SHALL remain held in IDLE until the next start.
REQ-028 din_valid in IDLE SHALL be ignored.
REQ-029 total SHALL wrap modulo 2^LEN_W.
REQ-030 num_active SHALL be combinational from the bin registers.
REQ-031 Simultaneous start and din_last in COUNT SHALL be resolved with start taking priority.

Reset
REQ-032 On rst_n low, the FSM SHALL go to IDLE and req, busy, every bin, total, num_active, oor_err and the saturation flag SHALL be 0.
REQ-033 A reset in COUNT or REQ SHALL abort the operation, and req SHALL drop without ack.

Configuration
REQ-034 When macro FREQ_HIST_SAT_EN is defined, bins SHALL saturate at 2^CNT_W-1, and a port sat_flag (output, 1) SHALL exist and be set sticky on any increment attempted at the maximum.
REQ-035 When FREQ_HIST_SAT_EN is undefined, bins SHALL wrap modulo 2^CNT_W and no sat_flag port SHALL exist.

Verification
REQ-036 Defaults; start, then din 0,1,1,9 with din_last on 9, then ack -> bins 0/1/9 = 1/2/1, total=4, num_active=3, req high 1 cycle after the last symbol and low 1 cycle after ack.
REQ-037 din=12 within a stream of 3 symbols -> oor_err=1, total=3, bins unaffected.
REQ-038 CNT_W=2; five din=3 -> with the macro bin3=3 and sat_flag=1; without the macro bin3=1.
REQ-039 start mid-stream after 5 symbols, then 2 symbols and last -> total=2 and only those 2 symbols binned.
REQ-040 In REQ, drive din_valid and start for 3 cycles, then ack -> outputs unchanged; next start clears them.
REQ-041 Assert rst_n low while req is high -> req=0, FSM in IDLE, all counts 0; ack afterward has no effect.

Source files
------------

// File: rtl/freq_hist.sv
// ============================================================================
// freq_hist -- symbol frequency histogram for an entropy-coding front end.
//
// Counts how often each symbol value 0..NUM_SYM-1 appears in a stream.
// start opens a new histogram. Each valid symbol then adds one to its bin and
// to the running total. din_last closes the histogram and raises req. The
// coding stage reads the frozen counts and answers with ack, which returns
// the block to idle. The counts stay readable until the next start.
//
// Parameters
//   SYM_W   symbol width in bits
//   NUM_SYM number of counted bins (2 .. 2**SYM_W)
//   CNT_W   width of each bin counter
//   LEN_W   width of the total-symbol counter (wraps)
//
// Ports
//   clk         clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle pulse that begins a new histogram
//   din_valid   qualifies din / din_last
//   din         input symbol
//   din_last    final symbol of the stream (only meaningful with din_valid)
//   ack         acknowledge from the coding stage
//   req         histogram-ready request (high while waiting for ack)
//   busy        high while counting or waiting for ack
//   cnt_out     packed bin counts, bin k at [k*CNT_W +: CNT_W]
//   total       number of accepted symbols, including out-of-range ones
//   num_active  number of nonzero bins (combinational)
//   oor_err     sticky: a symbol >= NUM_SYM was seen
//   sat_flag    sticky: a bin increment was attempted at full scale
//               (only when FREQ_HIST_SAT_EN is defined)
//
// Build option
//   FREQ_HIST_SAT_EN  when defined, bins saturate and sat_flag exists.
//                     When undefined, bins wrap and sat_flag is absent.
// ============================================================================
module freq_hist #(
    parameter int SYM_W   = 4,
    parameter int NUM_SYM = 10,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           din_valid,
    input  logic [SYM_W-1:0]               din,
    input  logic                           din_last,
    input  logic                           ack,
    output logic                           req,
    output logic                           busy,
    output logic [NUM_SYM*CNT_W-1:0]       cnt_out,
    output logic [LEN_W-1:0]               total,
    output logic [$clog2(NUM_SYM+1)-1:0]   num_active,
    output logic                           oor_err
`ifdef FREQ_HIST_SAT_EN
    ,
    output logic                           sat_flag
`endif
);

    localparam int NA_W = $clog2(NUM_SYM + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_REQ   = 2'd2;

    logic [1:0]       state_q;
    logic [CNT_W-1:0] bin_q [NUM_SYM];
    logic [LEN_W-1:0] total_q;
    logic             oor_q;

    logic do_clear;   // open or restart a histogram this cycle
    logic do_count;   // accept the symbol on din this cycle
    logic in_range;   // din addresses a real bin

    // start is honoured in IDLE and COUNT only. In COUNT it also wins over
    // any symbol (and any din_last) presented in the same cycle.
    assign do_clear = start && (state_q != S_REQ);
    assign do_count = din_valid && (state_q == S_COUNT) && !start;
    assign in_range = ({{(32-SYM_W){1'b0}}, din} < 32'(NUM_SYM));

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    // NOTE: every register in this file is updated with non-blocking (<=)
    // assignments, so all flops see pre-edge values regardless of the
    // order in which the always_ff blocks are evaluated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (start) state_q <= S_COUNT;
                S_COUNT: if (do_count && din_last) state_q <= S_REQ;
                S_REQ:   if (ack) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req  = (state_q == S_REQ);
    assign busy = (state_q == S_COUNT) || (state_q == S_REQ);

    // ------------------------------------------------------------------
    // Bin counters
    // ------------------------------------------------------------------
    // NOTE: the bins form a register array, not a RAM. They must read as
    // zero straight out of reset, so every entry is reset explicitly. Do not
    // map this array onto a memory macro, because a macro cannot clear in
    // one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_SYM; k++) bin_q[k] <= '0;
        end else if (do_clear) begin
            for (int k = 0; k < NUM_SYM; k++) bin_q[k] <= '0;
        end else if (do_count && in_range) begin
            for (int k = 0; k < NUM_SYM; k++) begin
                if (din == SYM_W'(k)) begin
`ifdef FREQ_HIST_SAT_EN
                    if (bin_q[k] != '1) bin_q[k] <= bin_q[k] + CNT_W'(1);
`else
                    bin_q[k] <= bin_q[k] + CNT_W'(1);
`endif
                end
            end
        end
    end

    // Out-of-range symbols still count toward the total.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_q <= '0;
            oor_q   <= 1'b0;
        end else if (do_clear) begin
            total_q <= '0;
            oor_q   <= 1'b0;
        end else if (do_count) begin
            total_q <= total_q + LEN_W'(1);
            if (!in_range) oor_q <= 1'b1;
        end
    end

`ifdef FREQ_HIST_SAT_EN
    logic sel_at_max;
    logic sat_q;

    always_comb begin
        sel_at_max = 1'b0;
        for (int k = 0; k < NUM_SYM; k++) begin
            if ((din == SYM_W'(k)) && (bin_q[k] == '1)) sel_at_max = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_q <= 1'b0;
        end else if (do_clear) begin
            sat_q <= 1'b0;
        end else if (do_count && in_range && sel_at_max) begin
            sat_q <= 1'b1;
        end
    end

    assign sat_flag = sat_q;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_SYM; g++) begin : g_pack
        assign cnt_out[g*CNT_W +: CNT_W] = bin_q[g];
    end

    assign total   = total_q;
    assign oor_err = oor_q;

    // NOTE: the accumulator gets a default before the loop. Without it,
    // always_comb would infer a latch for any path that skips the
    // assignment.
    always_comb begin
        num_active = '0;
        for (int k = 0; k < NUM_SYM; k++) begin
            if (bin_q[k] != '0) num_active = num_active + NA_W'(1);
        end
    end

endmodule

// File: tb/tb_freq_hist.sv
// ============================================================================
// tb_freq_hist -- directed self-checking bench for freq_hist.
//
// Two instances share all stimulus:
//   dut  : default parameters (CNT_W = 8)
//   dut2 : CNT_W = 2, used to check bin wrap or saturation
// Expected values are computed by hand. Inputs change 1 ns after the rising
// edge. Outputs are sampled 1 ns after the edge, once the design has settled.
// ============================================================================
`timescale 1ns/1ps
module tb_freq_hist;

    localparam int SYM_W   = 4;
    localparam int NUM_SYM = 10;
    localparam int CNT_W   = 8;
    localparam int LEN_W   = 16;
    localparam int NA_W    = $clog2(NUM_SYM + 1);

    logic                       clk = 1'b0;
    logic                       rst_n;
    logic                       start;
    logic                       din_valid;
    logic [SYM_W-1:0]           din;
    logic                       din_last;
    logic                       ack;

    logic                       req,  req2;
    logic                       busy, busy2;
    logic [NUM_SYM*CNT_W-1:0]   cnt_out;
    logic [NUM_SYM*2-1:0]       cnt_out2;
    logic [LEN_W-1:0]           total, total2;
    logic [NA_W-1:0]            num_active, num_active2;
    logic                       oor_err, oor_err2;
`ifdef FREQ_HIST_SAT_EN
    logic                       sat_flag, sat_flag2;
`endif

    int total_checks = 0;
    int bad_checks   = 0;

    always #5 clk = ~clk;

    freq_hist #(.SYM_W(SYM_W), .NUM_SYM(NUM_SYM), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .din_valid  (din_valid),
        .din        (din),
        .din_last   (din_last),
        .ack        (ack),
        .req        (req),
        .busy       (busy),
        .cnt_out    (cnt_out),
        .total      (total),
        .num_active (num_active),
        .oor_err    (oor_err)
`ifdef FREQ_HIST_SAT_EN
        ,
        .sat_flag   (sat_flag)
`endif
    );

    freq_hist #(.SYM_W(SYM_W), .NUM_SYM(NUM_SYM), .CNT_W(2), .LEN_W(LEN_W)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .din_valid  (din_valid),
        .din        (din),
        .din_last   (din_last),
        .ack        (ack),
        .req        (req2),
        .busy       (busy2),
        .cnt_out    (cnt_out2),
        .total      (total2),
        .num_active (num_active2),
        .oor_err    (oor_err2)
`ifdef FREQ_HIST_SAT_EN
        ,
        .sat_flag   (sat_flag2)
`endif
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Packed count vector for the default instance with one bin set.
    function automatic logic [NUM_SYM*CNT_W-1:0] bin8(input int k, input int v);
        logic [NUM_SYM*CNT_W-1:0] r;
        r = '0;
        r[k*CNT_W +: CNT_W] = CNT_W'(v);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int sym, input bit last);
        din_valid = 1'b1;
        din       = SYM_W'(sym);
        din_last  = last;
        tick();
        din_valid = 1'b0;
        din_last  = 1'b0;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; din_valid = 1'b0; din = '0; din_last = 1'b0; ack = 1'b0;
        #12;
        rst_n = 1'b1;
        tick();

        // ---- reset state ----
        check("rst_req",   req,        1'b0);
        check("rst_busy",  busy,       1'b0);
        check("rst_cnt",   cnt_out,    '0);
        check("rst_total", total,      '0);
        check("rst_nact",  num_active, '0);
        check("rst_oor",   oor_err,    1'b0);

        // ---- basic histogram: 0,1,1,9(last) ----
        pulse_start();
        check("start_busy", busy, 1'b1);
        check("start_req",  req,  1'b0);
        send(0, 0);
        check("first_cnt",   cnt_out, bin8(0, 1));
        check("first_total", total,   16'd1);
        send(1, 0);
        send(1, 0);
        // din_last without din_valid must not close the histogram
        din_last = 1'b1;
        tick();
        din_last = 1'b0;
        check("lone_last_req",  req,  1'b0);
        check("lone_last_busy", busy, 1'b1);
        send(9, 1);
        check("basic_req",   req,        1'b1);
        check("basic_cnt",   cnt_out,    bin8(0, 1) | bin8(1, 2) | bin8(9, 1));
        check("basic_total", total,      16'd4);
        check("basic_nact",  num_active, 4'd3);
        do_ack();
        check("ack_req",  req,  1'b0);
        check("ack_busy", busy, 1'b0);
        check("idle_hold_total", total, 16'd4);

        // ack and din_valid in IDLE are ignored
        do_ack();
        send(2, 1);
        check("idle_ign_busy",  busy,    1'b0);
        check("idle_ign_total", total,   16'd4);
        check("idle_ign_cnt",   cnt_out, bin8(0, 1) | bin8(1, 2) | bin8(9, 1));

        // ---- out-of-range symbol: 5,12,3(last) ----
        pulse_start();
        check("clr_oor_total", total, 16'd0);
        send(5, 0);
        send(12, 0);
        send(3, 1);
        check("oor_flag",  oor_err,    1'b1);
        check("oor_total", total,      16'd3);
        check("oor_cnt",   cnt_out,    bin8(5, 1) | bin8(3, 1));
        check("oor_nact",  num_active, 4'd2);
        do_ack();

        // ---- small counters: five 3s into CNT_W=2 ----
        pulse_start();
        check("clr_oor", oor_err, 1'b0);
        for (int i = 0; i < 5; i++) send(3, i == 4);
        check("sat8_cnt", cnt_out, bin8(3, 5));
        check("w2_nact",  num_active2, 4'd1);
`ifdef FREQ_HIST_SAT_EN
        check("sat_bin3", cnt_out2[7:6], 2'd3);
        check("sat_flag2", sat_flag2, 1'b1);
        check("sat_flag8", sat_flag,  1'b0);
`else
        check("wrap_bin3", cnt_out2[7:6], 2'd1);
`endif
        do_ack();

        // ---- restart mid-stream ----
        pulse_start();
`ifdef FREQ_HIST_SAT_EN
        check("clr_sat", sat_flag2, 1'b0);
`endif
        for (int i = 0; i < 5; i++) send(i, 0);
        check("pre_restart_total", total, 16'd5);
        // restart with a symbol and din_last in the same cycle: start wins
        start = 1'b1; din_valid = 1'b1; din = 4'd7; din_last = 1'b1;
        tick();
        start = 1'b0; din_valid = 1'b0; din_last = 1'b0;
        check("restart_total", total,   16'd0);
        check("restart_cnt",   cnt_out, '0);
        check("restart_req",   req,     1'b0);
        check("restart_busy",  busy,    1'b1);
        send(6, 0);
        send(6, 1);
        check("restart2_total", total,      16'd2);
        check("restart2_cnt",   cnt_out,    bin8(6, 2));
        check("restart2_nact",  num_active, 4'd1);
        check("restart2_req",   req,        1'b1);

        // ---- REQ freezes everything ----
        start = 1'b1; din_valid = 1'b1; din = 4'd1; din_last = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        start = 1'b0; din_valid = 1'b0; din_last = 1'b0;
        check("frz_req",   req,     1'b1);
        check("frz_total", total,   16'd2);
        check("frz_cnt",   cnt_out, bin8(6, 2));
        do_ack();
        check("frz_ack_req", req,     1'b0);
        check("frz_ack_cnt", cnt_out, bin8(6, 2));
        check("frz_ack_tot", total,   16'd2);
        pulse_start();
        check("frz_clr_cnt",  cnt_out,    '0);
        check("frz_clr_tot",  total,      16'd0);
        check("frz_clr_nact", num_active, 4'd0);

        // ---- reset while req is high ----
        send(4, 1);
        check("pre_rst_req", req, 1'b1);
        rst_n = 1'b0;
        #2;
        check("arst_req",   req,        1'b0);
        check("arst_busy",  busy,       1'b0);
        check("arst_total", total,      16'd0);
        check("arst_cnt",   cnt_out,    '0);
        check("arst_nact",  num_active, 4'd0);
        tick();
        rst_n = 1'b1;
        do_ack();
        check("post_rst_ack_req",  req,  1'b0);
        check("post_rst_ack_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
